// File: rtl/ucsbece154b_gshare_bp.sv
// ucsbece154b_gshare_bp: gshare predictor with a tagged direct-mapped BTB,
// a PHT of 2-bit saturating counters and a global history register.
module ucsbece154b_gshare_bp #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pc_i,
    output logic                    BranchTaken_o,
    output logic [31:0]             BTBtarget_o,
    output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
    input  logic                    BTBwe_i,
    input  logic [31:0]             BTBwritepc_i,
    input  logic [31:0]             BTBwritedata_i,
    input  logic [6:0]              BTBop_i,
    input  logic                    PHTwe_i,
    input  logic                    PHTincrement_i,
    input  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_i,
    input  logic                    GHRreset_i
);
    localparam int BI = $clog2(NUM_BTB_ENTRIES);
    localparam int TW = 30 - BI;
    localparam int PN = 1 << NUM_GHR_BITS;

    logic [NUM_BTB_ENTRIES-1:0] valid, is_jump, is_branch;
    logic [TW-1:0]              tag [NUM_BTB_ENTRIES];
    logic [31:0]                target [NUM_BTB_ENTRIES];
    logic [1:0]                 pht [PN];
    logic [NUM_GHR_BITS-1:0]    ghr;
    logic [BI-1:0]              ridx, widx;
    logic [1:0]                 wctr;
    logic                       hit;

    assign ridx = pc_i[BI+1:2];
    assign widx = BTBwritepc_i[BI+1:2];
    assign wctr = pht[PHTwriteaddress_i];
    // Outputs are forced quiet while reset is held since state clears only at the edge
    assign hit = !reset && valid[ridx] && tag[ridx] == pc_i[31:BI+2];
    assign PHTreadaddress_o = reset ? pc_i[NUM_GHR_BITS+1:2] : ghr ^ pc_i[NUM_GHR_BITS+1:2];
    assign BranchTaken_o = hit && (is_jump[ridx] || (is_branch[ridx] && pht[PHTreadaddress_o][1]));
    assign BTBtarget_o = hit ? target[ridx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            ghr <= '0;
            for (int i = 0; i < PN; i++) pht[i] <= 2'b01;
        end else begin
            if (BTBwe_i) valid[widx] <= 1'b1;
            if (PHTwe_i) pht[PHTwriteaddress_i] <= PHTincrement_i ? (wctr == 2'b11 ? wctr : wctr + 2'd1)
                                                                  : (wctr == 2'b00 ? wctr : wctr - 2'd1);
            ghr <= GHRreset_i ? '0 : PHTwe_i ? {ghr[NUM_GHR_BITS-2:0], PHTincrement_i} : ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (BTBwe_i) begin
            tag[widx] <= BTBwritepc_i[31:BI+2];
            target[widx] <= BTBwritedata_i;
            is_jump[widx] <= BTBop_i == 7'b1101111 || BTBop_i == 7'b1100111;
            is_branch[widx] <= BTBop_i == 7'b1100011;
        end
    end
endmodule
